pifo_io_arbiter: RTL and testbench

Shares the single push/pop port of the PIFO tree IO port between `NREQ` independent requesters. Each cycle it picks one eligible requester round-robin and registers its push or pop onto the tree port. It samples the tree's task-fail flag in the issue cycle: a failed requester backs off, a successful one is acknowledged. Pop results are routed back to the requester that issued the pop. It sits directly between scheduler clients and the IO port.

---
 rtl/pifo_arb_pkg.sv | 38 +++
 rtl/pifo_rr_arb.sv | 42 ++++
 rtl/pifo_io_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_pifo_io_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// pifo_arb_pkg
//   Shared types and default widths for the PIFO IO-port arbiter.
//   - op_t      : push / pop selector carried through the issue stage
//   - issue_t   : contents of the single issue register (one op per cycle)
//   - ret_t     : one stage of the pop-return pipe (which requester to answer)
//   The ARB_* localparams are the default widths; the top's parameters default
//   to them and the records below are sized from them.
// -----------------------------------------------------------------------------
package pifo_arb_pkg;

    localparam int ARB_PTW       = 16;
    localparam int ARB_MTW       = 44;
    localparam int ARB_DW        = ARB_MTW + ARB_PTW;
    localparam int ARB_TREE_NUM  = 16;
    localparam int ARB_TREE_BITS = $clog2(ARB_TREE_NUM);
    localparam int ARB_NREQ      = 4;
    localparam int ARB_REQ_BITS  = $clog2(ARB_NREQ);

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_t;

    typedef struct packed {
        logic                     valid;
        op_t                      op;
        logic [ARB_REQ_BITS-1:0]  req_id;
        logic [ARB_TREE_BITS-1:0] tree_id;
        logic [ARB_DW-1:0]        data;
    } issue_t;

    typedef struct packed {
        logic                    valid;
        logic [ARB_REQ_BITS-1:0] req_id;
    } ret_t;

endpackage

// File: rtl/pifo_rr_arb.sv
// -----------------------------------------------------------------------------
// pifo_rr_arb
//   Combinational round-robin arbiter. Scans requests starting at i_ptr and
//   wrapping modulo NREQ (NREQ must be a power of 2); the first set request
//   wins. The pointer register is owned by the parent.
//   Ports:
//     i_req      in  NREQ      request vector
//     i_ptr      in  REQ_BITS  highest-priority index this cycle
//     o_gnt      out NREQ      one-hot grant
//     o_gnt_idx  out REQ_BITS  index of the granted requester
//     o_gnt_any  out 1         some requester was granted
// -----------------------------------------------------------------------------
module pifo_rr_arb #(
    parameter  int NREQ     = 4,
    localparam int REQ_BITS = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]     i_req,
    input  logic [REQ_BITS-1:0] i_ptr,
    output logic [NREQ-1:0]     o_gnt,
    output logic [REQ_BITS-1:0] o_gnt_idx,
    output logic                o_gnt_any
);

    logic [REQ_BITS-1:0] idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Power-of-2 NREQ makes the truncating add a free modulo.
            idx = i_ptr + REQ_BITS'(i);
            if (!o_gnt_any && i_req[idx]) begin
                o_gnt_any  = 1'b1;
                o_gnt_idx  = idx;
                o_gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pifo_io_arbiter.sv
// -----------------------------------------------------------------------------
// pifo_io_arbiter
//   Shares the single push/pop port of a PIFO tree between NREQ requesters.
//   Each cycle one eligible requester is picked round-robin and its op is
//   registered onto the tree port. The tree's fail flag is sampled in that
//   issue cycle: success acks the requester, failure pulses o_req_fail and
//   blocks that requester for BACKOFF cycles. Successful pops are tracked
//   through a POP_LAT-deep return pipe and the tree's pop data is routed back,
//   registered, to the requester that issued the pop.
//
//   Handshake: a requester raises i_req_valid[r] with pop/tree/data stable and
//   holds them until either o_req_ready[r] (op accepted) or o_req_fail[r] (op
//   dropped by the tree) pulses; both are one-cycle combinational pulses in the
//   issue cycle. After a fail the requester may withdraw or change its op.
//
//   Ports:
//     i_clk, i_arst_n          clock; synchronous active-low reset
//     i_req_valid/pop          per-requester request present / 1 = pop
//     i_req_tree_id, i_req_data per-requester target tree and push entry
//     o_req_ready, o_req_fail  per-requester accept / reject pulses
//     o_rsp_valid, o_rsp_data  pop result and the requester it belongs to
//     o_rsp_empty              pop result was all-ones (tree empty)
//     o_tree_id, o_push, o_push_data, o_pop   tree port drive
//     i_task_fail, i_pop_data  tree port fail flag and pop data
// -----------------------------------------------------------------------------
module pifo_io_arbiter
    import pifo_arb_pkg::*;
#(
    parameter  int PTW           = ARB_PTW,
    parameter  int MTW           = ARB_MTW,
    parameter  int TREE_NUM      = ARB_TREE_NUM,
    parameter  int NREQ          = ARB_NREQ,
    parameter  int POP_LAT       = 2,
    parameter  int BACKOFF       = 4,
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int REQ_BITS      = $clog2(NREQ),
    localparam int DW            = MTW + PTW
) (
    input  logic                          i_clk,
    input  logic                          i_arst_n,
    input  logic [NREQ-1:0]               i_req_valid,
    input  logic [NREQ-1:0]               i_req_pop,
    input  logic [NREQ*TREE_NUM_BITS-1:0] i_req_tree_id,
    input  logic [NREQ*DW-1:0]            i_req_data,
    output logic [NREQ-1:0]               o_req_ready,
    output logic [NREQ-1:0]               o_req_fail,
    output logic [NREQ-1:0]               o_rsp_valid,
    output logic [DW-1:0]                 o_rsp_data,
    output logic                          o_rsp_empty,
    output logic [TREE_NUM_BITS-1:0]      o_tree_id,
    output logic                          o_push,
    output logic [DW-1:0]                 o_push_data,
    output logic                          o_pop,
    input  logic                          i_task_fail,
    input  logic [DW-1:0]                 i_pop_data
);

    localparam int BO_BITS = $clog2(BACKOFF + 1);

    issue_t              issue_q, issue_d;
    logic [REQ_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [BO_BITS-1:0]  backoff_q [NREQ];
    logic [BO_BITS-1:0]  backoff_d [NREQ];
    ret_t                pipe_q [POP_LAT];
    ret_t                pipe_d [POP_LAT];
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]       rsp_data_q, rsp_data_d;
    logic                rsp_empty_q, rsp_empty_d;

    logic [NREQ-1:0]     eligible;
    logic [NREQ-1:0]     gnt;
    logic [REQ_BITS-1:0] gnt_idx;
    logic                gnt_any;
    logic                issue_ok;
    logic                issue_fail;
    ret_t                tail;

    // A requester sitting in the issue stage is masked so it cannot be granted
    // twice before it has seen its ready/fail.
    always_comb begin
        eligible = '0;
        for (int r = 0; r < NREQ; r++) begin
            eligible[r] = i_req_valid[r] && (backoff_q[r] == '0) &&
                          !(issue_q.valid && issue_q.req_id == REQ_BITS'(r));
        end
    end

    pifo_rr_arb #(
        .NREQ (NREQ)
    ) u_rr_arb (
        .i_req     (eligible),
        .i_ptr     (rr_ptr_q),
        .o_gnt     (gnt),
        .o_gnt_idx (gnt_idx),
        .o_gnt_any (gnt_any)
    );

    // Issue register load; cleared when nobody is granted so the tree port
    // fields read as 0 on idle cycles.
    always_comb begin
        issue_d  = '0;
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            issue_d.valid   = 1'b1;
            issue_d.op      = i_req_pop[gnt_idx] ? OP_POP : OP_PUSH;
            issue_d.req_id  = gnt_idx;
            issue_d.tree_id = i_req_tree_id[gnt_idx*TREE_NUM_BITS +: TREE_NUM_BITS];
            if (!i_req_pop[gnt_idx]) begin
                issue_d.data = i_req_data[gnt_idx*DW +: DW];
            end
            rr_ptr_d = gnt_idx + 1'b1;
        end
    end

    assign issue_ok   = issue_q.valid && !i_task_fail;
    assign issue_fail = issue_q.valid &&  i_task_fail;

    assign o_push      = issue_q.valid && (issue_q.op == OP_PUSH);
    assign o_pop       = issue_q.valid && (issue_q.op == OP_POP);
    assign o_tree_id   = issue_q.tree_id;
    assign o_push_data = issue_q.data;
    assign o_req_ready = issue_ok   ? (NREQ'(1) << issue_q.req_id) : '0;
    assign o_req_fail  = issue_fail ? (NREQ'(1) << issue_q.req_id) : '0;

    // Backoff: loaded on a fail, then counts down to 0. Counters are
    // independent, so a load on one and an expiry on another never interact.
    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            backoff_d[r] = backoff_q[r];
            if (issue_fail && issue_q.req_id == REQ_BITS'(r)) begin
                backoff_d[r] = BO_BITS'(BACKOFF);
            end else if (backoff_q[r] != '0) begin
                backoff_d[r] = backoff_q[r] - 1'b1;
            end
        end
    end

    // Return pipe: only accepted pops are tracked, so a failed pop never
    // produces a response.
    always_comb begin
        pipe_d[0].valid  = issue_ok && (issue_q.op == OP_POP);
        pipe_d[0].req_id = issue_q.req_id;
        for (int k = 1; k < POP_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    assign tail = pipe_q[POP_LAT-1];

    // The tail stage lines up with the cycle the tree drives i_pop_data.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_empty_d = 1'b0;
        if (tail.valid) begin
            rsp_valid_d = NREQ'(1) << tail.req_id;
            rsp_data_d  = i_pop_data;
            rsp_empty_d = &i_pop_data;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_empty = rsp_empty_q;

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            issue_q     <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_empty_q <= 1'b0;
            for (int r = 0; r < NREQ; r++) begin
                backoff_q[r] <= '0;
            end
            for (int k = 0; k < POP_LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            issue_q     <= issue_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_empty_q <= rsp_empty_d;
            for (int r = 0; r < NREQ; r++) begin
                backoff_q[r] <= backoff_d[r];
            end
            for (int k = 0; k < POP_LAT; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pifo_io_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pifo_io_arbiter
//   Directed bench for pifo_io_arbiter: reset, round-robin order, fail/backoff,
//   pop return, empty and back-to-back pops, reset with a pop in flight.
//   A small tree model returns queued pop values POP_LAT cycles after o_pop;
//   a response scoreboard matches every o_rsp_valid against exp_q.
// -----------------------------------------------------------------------------
module tb_pifo_io_arbiter;

    localparam int NREQ    = 4;
    localparam int TB      = 4;
    localparam int DW      = 60;
    localparam int POP_LAT = 2;
    localparam int SBW     = NREQ + DW + 1;

    logic                 clk;
    logic                 i_arst_n;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ-1:0]      i_req_pop;
    logic [NREQ*TB-1:0]   i_req_tree_id;
    logic [NREQ*DW-1:0]   i_req_data;
    logic [NREQ-1:0]      o_req_ready;
    logic [NREQ-1:0]      o_req_fail;
    logic [NREQ-1:0]      o_rsp_valid;
    logic [DW-1:0]        o_rsp_data;
    logic                 o_rsp_empty;
    logic [TB-1:0]        o_tree_id;
    logic                 o_push;
    logic [DW-1:0]        o_push_data;
    logic                 o_pop;
    logic                 i_task_fail;
    logic [DW-1:0]        i_pop_data;

    int n_vec;
    int n_err;

    logic [SBW-1:0] exp_q[$];
    logic [DW-1:0]  pop_vals[$];
    logic [DW:0]    pd_line [POP_LAT];

    int             exp_id [5] = '{0, 1, 2, 3, 0};
    int             exp_tr [5] = '{1, 2, 3, 4, 9};
    logic [DW-1:0]  exp_dt [5] = '{60'h100, 60'h101, 60'h102, 60'h103, 60'h200};
    logic [DW-1:0]  all_ones;
    int             lat;

    pifo_io_arbiter #(
        .PTW      (16),
        .MTW      (44),
        .TREE_NUM (16),
        .NREQ     (NREQ),
        .POP_LAT  (POP_LAT),
        .BACKOFF  (4)
    ) dut (
        .i_clk         (clk),
        .i_arst_n      (i_arst_n),
        .i_req_valid   (i_req_valid),
        .i_req_pop     (i_req_pop),
        .i_req_tree_id (i_req_tree_id),
        .i_req_data    (i_req_data),
        .o_req_ready   (o_req_ready),
        .o_req_fail    (o_req_fail),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_empty   (o_rsp_empty),
        .o_tree_id     (o_tree_id),
        .o_push        (o_push),
        .o_push_data   (o_push_data),
        .o_pop         (o_pop),
        .i_task_fail   (i_task_fail),
        .i_pop_data    (i_pop_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic p,
                           input logic [TB-1:0] t, input logic [DW-1:0] d);
        i_req_valid[r]              = v;
        i_req_pop[r]                = p;
        i_req_tree_id[r*TB +: TB]   = t;
        i_req_data[r*DW +: DW]      = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_push"},  o_push,      0);
        check({tag, "_pop"},   o_pop,       0);
        check({tag, "_tree"},  o_tree_id,   0);
        check({tag, "_pdata"}, o_push_data, 0);
        check({tag, "_ready"}, o_req_ready, 0);
        check({tag, "_fail"},  o_req_fail,  0);
        check({tag, "_rspv"},  o_rsp_valid, 0);
        check({tag, "_rspd"},  o_rsp_data,  0);
        check({tag, "_rspe"},  o_rsp_empty, 0);
    endtask

    // ---------------- tree model ----------------
    // Hands out the next queued value for every o_pop seen and presents it on
    // i_pop_data POP_LAT cycles after the o_pop cycle.
    initial begin
        for (int k = 0; k < POP_LAT; k++) pd_line[k] = '0;
    end

    always @(posedge clk) begin : tree_model
        logic [DW-1:0] v;
        v = '0;
        if (o_pop && pop_vals.size() > 0) v = pop_vals.pop_front();
        pd_line[0] <= {o_pop, v};
        for (int k = 1; k < POP_LAT; k++) pd_line[k] <= pd_line[k-1];
    end

    assign i_pop_data = pd_line[POP_LAT-1][DW] ? pd_line[POP_LAT-1][DW-1:0] : '0;

    // ---------------- response scoreboard ----------------
    always @(negedge clk) begin : rsp_sb
        logic [SBW-1:0] e;
        if (o_rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", o_rsp_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_rsp", {o_rsp_valid, o_rsp_data, o_rsp_empty}, e);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec         = 0;
        n_err         = 0;
        all_ones      = '1;
        i_arst_n      = 1'b0;
        i_req_valid   = '0;
        i_req_pop     = '0;
        i_req_tree_id = '0;
        i_req_data    = '0;
        i_task_fail   = 1'b0;

        // Reset: all requesters valid while reset is held for 3 edges.
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, 1'b0, TB'(r + 1), DW'(32'h100 + r));
        nxt();
        nxt();
        #1;
        check_all_zero("rst");
        nxt();
        i_arst_n = 1'b1;
        #1;
        check("rst_rel_push", o_push, 0);

        // Round-robin: issue order 0,1,2,3,0; requester 0 re-requests tree 9.
        for (int k = 0; k < 5; k++) begin
            nxt();
            if (k > 0) set_req(exp_id[k-1], 1'b0, 1'b0, '0, '0);
            if (k == 1) set_req(0, 1'b1, 1'b0, 4'd9, 60'h200);
            #1;
            check("rr_push",  o_push,      1);
            check("rr_tree",  o_tree_id,   exp_tr[k]);
            check("rr_data",  o_push_data, exp_dt[k]);
            check("rr_ready", o_req_ready, 1 << exp_id[k]);
        end
        nxt();
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        check("rr_idle_push",  o_push,      0);
        check("rr_idle_ready", o_req_ready, 0);

        // Fail and backoff: requester 2 fails on tree 5; requester 1 slips in
        // during the backoff; requester 2 re-issues 6 cycles after its fail.
        nxt();
        set_req(2, 1'b1, 1'b0, 4'd5, 60'h300);
        #1;
        check("bo_pre_push", o_push, 0);
        nxt();
        i_task_fail = 1'b1;
        #1;
        check("bo_fail",   o_req_fail,  4'b0100);
        check("bo_noack",  o_req_ready, 0);
        check("bo_push",   o_push,      1);
        check("bo_tree",   o_tree_id,   5);
        for (int off = 1; off <= 6; off++) begin
            nxt();
            i_task_fail = 1'b0;
            if (off == 2) set_req(1, 1'b1, 1'b0, 4'd7, 60'h400);
            if (off == 4) set_req(1, 1'b0, 1'b0, '0, '0);
            #1;
            check("bo_fail_pulse", o_req_fail, 0);
            check("bo_wait_push",  o_push, (off == 3 || off == 6) ? 1 : 0);
            check("bo_wait_tree",  o_tree_id, (off == 3) ? 7 : (off == 6) ? 5 : 0);
            check("bo_wait_ready", o_req_ready, (off == 3) ? 4'b0010 : (off == 6) ? 4'b0100 : 4'b0000);
            if (off == 1) check("bo_idle_pdata", o_push_data, 0);
        end
        nxt();
        set_req(2, 1'b0, 1'b0, '0, '0);
        #1;

        // Pop return: requester 1 pops tree 3, tree returns 0x123.
        nxt();
        set_req(1, 1'b1, 1'b1, 4'd3, '0);
        pop_vals.push_back(60'h123);
        exp_q.push_back({4'b0010, 60'h123, 1'b0});
        #1;
        nxt();
        #1;
        check("pop_pop",   o_pop,       1);
        check("pop_push",  o_push,      0);
        check("pop_tree",  o_tree_id,   3);
        check("pop_ready", o_req_ready, 4'b0010);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            nxt();
            if (i == 1) set_req(1, 1'b0, 1'b0, '0, '0);
            #1;
            if (o_rsp_valid != '0) begin
                lat = i;
                break;
            end
        end
        check("pop_lat",   lat,         3);
        check("pop_rspv",  o_rsp_valid, 4'b0010);
        check("pop_rspd",  o_rsp_data,  60'h123);
        check("pop_rspe",  o_rsp_empty, 0);

        // Back-to-back pops: requester 0 (tree empty) then requester 3 (0x7).
        nxt();
        set_req(0, 1'b1, 1'b1, 4'd2, '0);
        pop_vals.push_back(all_ones);
        pop_vals.push_back(60'h7);
        exp_q.push_back({4'b0001, all_ones, 1'b1});
        exp_q.push_back({4'b1000, 60'h7, 1'b0});
        #1;
        nxt();
        set_req(3, 1'b1, 1'b1, 4'd4, '0);
        #1;
        check("b2b_pop0",   o_pop,       1);
        check("b2b_ready0", o_req_ready, 4'b0001);
        check("b2b_tree0",  o_tree_id,   2);
        nxt();
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        check("b2b_pop3",   o_pop,       1);
        check("b2b_ready3", o_req_ready, 4'b1000);
        check("b2b_tree3",  o_tree_id,   4);
        nxt();
        set_req(3, 1'b0, 1'b0, '0, '0);
        #1;
        check("b2b_rsp_none", o_rsp_valid, 0);
        nxt();
        #1;
        check("b2b_rspv0", o_rsp_valid, 4'b0001);
        check("b2b_rspd0", o_rsp_data,  all_ones);
        check("b2b_rspe0", o_rsp_empty, 1);
        nxt();
        #1;
        check("b2b_rspv3", o_rsp_valid, 4'b1000);
        check("b2b_rspd3", o_rsp_data,  60'h7);
        check("b2b_rspe3", o_rsp_empty, 0);
        nxt();
        #1;
        check("b2b_rsp_done", o_rsp_valid, 0);

        // Reset mid-flight: reset one cycle after a pop issues; no response.
        nxt();
        set_req(2, 1'b1, 1'b1, 4'd6, '0);
        pop_vals.push_back(60'h55);
        #1;
        nxt();
        #1;
        check("mid_pop",   o_pop,       1);
        check("mid_ready", o_req_ready, 4'b0100);
        nxt();
        set_req(2, 1'b0, 1'b0, '0, '0);
        i_arst_n = 1'b0;
        #1;
        nxt();
        #1;
        check_all_zero("mid_rst");
        nxt();
        i_arst_n = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            nxt();
            #1;
            check("mid_no_rspv", o_rsp_valid, 0);
            check("mid_no_rspd", o_rsp_data,  0);
        end

        check("rsp_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
